chip8_scanout: RTL

CHIP8_SCANOUT -- requirements
Module: chip8_scanout

---
 rtl/chip8_scanout.sv | 109 ++++++++++
 1 files changed

// File: rtl/chip8_scanout.sv
// CHIP-8 64x32 framebuffer scanout: maps video timing to VRAM byte reads, realigns
// the selected pixel with the delayed sync strobes, and swaps buffers at frame boundaries.
module chip8_scanout #(
  parameter int SCALE_LOG2 = 4,
  parameter int H_OFFSET   = 128,
  parameter int V_OFFSET   = 104
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_draw_in,
  input  logic        new_frame_in,
  input  logic        swap_req_in,
  output logic [7:0]  vram_addr_out,
  output logic        vram_buf_out,
  input  logic [7:0]  vram_data_in,
  output logic        pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic        front_buf_out,
  output logic        swap_ack_out
);

  localparam logic [11:0] H_LO = 12'(H_OFFSET);
  localparam logic [11:0] H_HI = 12'(H_OFFSET + (64 << SCALE_LOG2));
  localparam logic [10:0] V_LO = 11'(V_OFFSET);
  localparam logic [10:0] V_HI = 11'(V_OFFSET + (32 << SCALE_LOG2));

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  logic        in_window;
  logic [11:0] hdiff;
  logic [10:0] vdiff;
  logic [5:0]  x;
  logic [4:0]  y;
  logic        unused_diff_bits;

  // Stage 1..3 copies of in_window / x[2:0]; stage 3 lines up with vram_data_in.
  logic [2:0]      win_d;
  logic [2:0][2:0] xlo_d;
  logic [3:0][2:0] sync_d;

  state_t state, state_nxt;
  logic   do_swap;

  always_comb begin
    hdiff     = {1'b0, hcount_in} - H_LO;
    vdiff     = {1'b0, vcount_in} - V_LO;
    x         = hdiff[SCALE_LOG2 +: 6];
    y         = vdiff[SCALE_LOG2 +: 5];
    in_window = ({1'b0, hcount_in} >= H_LO) && ({1'b0, hcount_in} < H_HI) &&
                ({1'b0, vcount_in} >= V_LO) && ({1'b0, vcount_in} < V_HI);
  end

  assign unused_diff_bits = ^{hdiff, vdiff};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vram_addr_out <= '0;
      win_d         <= '0;
      xlo_d         <= '0;
      sync_d        <= '0;
      pixel_out     <= 1'b0;
    end else begin
      if (in_window) vram_addr_out <= {y, x[5:3]};
      win_d     <= {win_d[1:0], in_window};
      xlo_d     <= {xlo_d[1:0], x[2:0]};
      sync_d    <= {sync_d[2:0], {hsync_in, vsync_in, active_draw_in}};
      pixel_out <= win_d[2] ? vram_data_in[3'd7 - xlo_d[2]] : 1'b0;
    end
  end

  assign {hsync_out, vsync_out, active_draw_out} = sync_d[3];

  // Swap FSM: state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Swap FSM: next state
  always_comb begin
    state_nxt = state;
    if (do_swap)          state_nxt = IDLE;
    else if (swap_req_in) state_nxt = PENDING;
  end

  // Swap FSM: outputs (a request coinciding with new_frame swaps on that frame)
  always_comb begin
    do_swap = new_frame_in && ((state == PENDING) || swap_req_in);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      front_buf_out <= 1'b0;
      swap_ack_out  <= 1'b0;
    end else begin
      swap_ack_out <= do_swap;
      if (do_swap) front_buf_out <= ~front_buf_out;
    end
  end

  assign vram_buf_out = front_buf_out;

endmodule
